// File: rtl/fixed_to_float_pkg.sv
// ---------------------------------------------------------------------------
// fixed_to_float_pkg
//
// Shared definitions for the Q1.31 fixed-point to IEEE-754 single-precision
// converter: the controller state type, the exponent/fraction constants and
// a helper that turns a leading-zero count into a biased exponent.
//
// Contents:
//   state_e       controller states IDLE, ABS, NORM, PACK, DONE
//   EXP_OFFSET    biased exponent of a leading one at bit 0 (bit p -> p+96)
//   FRAC_W        stored fraction width of a single-precision word
//   NORM_STEPS    number of binary-search normalisation steps (16,8,4,2,1)
//   LATENCY       enabled edges from accepted start to registered done
//   biased_exp()  leading-zero count -> biased exponent
// ---------------------------------------------------------------------------
package fixed_to_float_pkg;

  localparam int EXP_OFFSET = 96;
  localparam int FRAC_W     = 23;
  localparam int NORM_STEPS = 5;
  localparam int LATENCY    = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    NORM = 3'd2,
    PACK = 3'd3,
    DONE = 3'd4
  } state_e;

  // A leading one at bit p of the 32-bit magnitude has lz = 31 - p, and
  // the Q1.31 weight of bit 31 is 2^0, so the biased exponent is
  // 127 - lz, i.e. EXP_OFFSET + 31 - lz.
  function automatic logic [7:0] biased_exp(input logic [4:0] lz);
    return 8'(EXP_OFFSET + 31 - int'(lz));
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// ---------------------------------------------------------------------------
// fp_round_pack
//
// Combinational packer: takes a sign, a biased exponent and a left-
// normalised 32-bit magnitude (leading one in bit 31, or all zero) and
// builds the 32-bit IEEE-754 single-precision word.
//
// Configuration macro: FIXED_TO_FLOAT_ROUND_EN
//   defined   -> round to nearest, ties to even, using guard/sticky/LSB;
//                a fraction carry-out clears the fraction and bumps the
//                exponent.
//   undefined -> truncate the fraction (guard and sticky ignored).
//
// Ports:
//   sign_i   sign of the original value (1 = negative)
//   exp_i    biased exponent for the normalised magnitude (96..127)
//   mag_i    normalised magnitude, implicit one in bit 31
//   word_o   packed single-precision word (+0.0 when mag_i is zero)
// ---------------------------------------------------------------------------
module fp_round_pack
  import fixed_to_float_pkg::*;
(
  input  logic        sign_i,
  input  logic [7:0]  exp_i,
  input  logic [31:0] mag_i,
  output logic [31:0] word_o
);

  logic [FRAC_W-1:0] frac;
  logic [FRAC_W-1:0] fracOut;
  logic [7:0]        expOut;
`ifdef FIXED_TO_FLOAT_ROUND_EN
  logic              guard;
  logic              sticky;
  logic              roundUp;
  logic [FRAC_W:0]   fracRnd;
`endif

  // Split the normalised magnitude into the stored fraction (the bits just
  // below the implicit one) and, when rounding, the guard and sticky bits.
  // An all-zero magnitude bypasses everything and yields +0.0, since the
  // exponent range never reaches the zero/denormal encoding by itself.
  always_comb begin
    frac    = mag_i[30 -: FRAC_W];
    fracOut = frac;
    expOut  = exp_i;
`ifdef FIXED_TO_FLOAT_ROUND_EN
    guard   = mag_i[30-FRAC_W];
    sticky  = |mag_i[30-FRAC_W-1:0];
    roundUp = guard & (sticky | frac[0]);
    fracRnd = {1'b0, frac} + {{FRAC_W{1'b0}}, roundUp};
    if (fracRnd[FRAC_W]) begin
      fracOut = '0;
      expOut  = exp_i + 8'd1;
    end else begin
      fracOut = fracRnd[FRAC_W-1:0];
      expOut  = exp_i;
    end
`endif
    if (mag_i == 32'd0) begin
      word_o = 32'd0;
    end else begin
      word_o = {sign_i, expOut, fracOut};
    end
  end

endmodule

// File: rtl/fixed_to_float.sv
// ---------------------------------------------------------------------------
// fixed_to_float
//
// Multi-cycle converter from a signed Q1.31 fixed-point value (e.g. a cordic
// cosine output) to an IEEE-754 single-precision word. The controller walks
// IDLE -> ABS -> NORM (5 cycles) -> PACK -> DONE -> IDLE, giving a fixed
// latency of 7 enabled clock edges from the accepted start to done.
//
// Configuration macro: FIXED_TO_FLOAT_ROUND_EN (see fp_round_pack); when
// undefined the fraction is truncated. Latency and ports are identical.
//
// Ports:
//   clock   single clock, all state updates on its rising edge
//   aclr    synchronous active-high reset, wins over clk_en
//   clk_en  clock enable; all state holds while low
//   start   conversion request, only honoured in IDLE
//   dataa   Q1.31 input, captured on the accepted start edge
//   done    one-cycle pulse (held while frozen) marking a fresh result
//   result  packed single-precision word, held until the next done
// ---------------------------------------------------------------------------
module fixed_to_float
  import fixed_to_float_pkg::*;
(
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  lz_q, lz_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic [4:0]  shiftAmt;
  logic [31:0] topMask;
  logic [31:0] packWord;

  // Rounding/packing is purely combinational; its output is only
  // registered into result while the controller sits in PACK.
  fp_round_pack u_pack (
    .sign_i (sign_q),
    .exp_i  (biased_exp(lz_q)),
    .mag_i  (mag_q),
    .word_o (packWord)
  );

  // Controller state register. Reset is synchronous and overrides the
  // clock enable so an abort always lands in IDLE.
  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Datapath registers follow the same reset/enable rules as the state,
  // so a freeze holds the whole conversion, including a pending done.
  always_ff @(posedge clock) begin
    if (aclr) begin
      data_q   <= 32'd0;
      sign_q   <= 1'b0;
      mag_q    <= 32'd0;
      lz_q     <= 5'd0;
      step_q   <= 3'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      data_q   <= data_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      lz_q     <= lz_d;
      step_q   <= step_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath logic. NORM is a binary search for the leading
  // one: step k tests whether the top (16 >> k) bits are all zero and, if
  // so, shifts them out and adds the shift to the leading-zero count. After
  // five steps bit 31 holds the leading one (or the value is zero, in which
  // case lz saturates at 31 and the packer outputs +0.0). done is only set
  // on the PACK -> DONE transition, so it drops on the next enabled edge.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    lz_d     = lz_q;
    step_d   = step_q;
    result_d = result_q;
    done_d   = 1'b0;
    shiftAmt = 5'd16 >> step_q;
    topMask  = ~(32'hFFFF_FFFF >> shiftAmt);

    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = dataa;
          state_d = ABS;
        end
      end

      // Two's-complement negate of 0x80000000 wraps back to 0x80000000,
      // which read as unsigned is exactly the required 2^31 magnitude.
      ABS: begin
        sign_d  = data_q[31];
        mag_d   = data_q[31] ? (~data_q + 32'd1) : data_q;
        lz_d    = 5'd0;
        step_d  = 3'd0;
        state_d = NORM;
      end

      NORM: begin
        if ((mag_q & topMask) == 32'd0) begin
          mag_d = mag_q << shiftAmt;
          lz_d  = lz_q + shiftAmt;
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'(NORM_STEPS - 1)) begin
          state_d = PACK;
        end
      end

      PACK: begin
        result_d = packWord;
        done_d   = 1'b1;
        state_d  = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/fixed_to_float.md
FIXED_TO_FLOAT -- requirements
Module: fixed_to_float

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 aclr  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 clk_en  input  1  clock enable; while low, all state SHALL hold (aclr excepted).
REQ-005 start  input  1  request; sampled only in IDLE with clk_en high.
REQ-006 dataa  input  32  signed two's-complement Q1.31 value (cordic cosine output); captured on the start edge.
REQ-007 done  output  1  one-cycle pulse; result is valid while done is high.
REQ-008 result  output  32  IEEE-754 single-precision encoding of dataa; held until the next done.

Function
REQ-009 The FSM SHALL have states IDLE, ABS, NORM, PACK and DONE.
REQ-010 Transitions: IDLE->ABS on start (dataa registered); ABS->NORM; NORM stays 5 enabled cycles; NORM->PACK; PACK->DONE; DONE->IDLE.
REQ-011 ABS SHALL register sign = dataa[31] and a 32-bit unsigned magnitude; 0x80000000 SHALL give magnitude 2^31.
REQ-012 NORM SHALL left-normalise by binary search (steps of 16, 8, 4, 2, 1, one step per cycle) and accumulate the leading-zero count lz (0..31).
REQ-013 The biased exponent SHALL be 127 - lz; equivalently, leading-one bit p gives exponent p + 96.
REQ-014 Fraction: the 23 bits below the leading one; guard = next bit, sticky = OR of the remaining bits.
REQ-015 Fixed latency: with start sampled at enabled edge 0, result and done SHALL be registered at enabled edge 7.
REQ-016 done SHALL be high for exactly one enabled cycle (the DONE state) and SHALL be low otherwise.
REQ-017 start outside IDLE SHALL be ignored, with no queuing; the earliest next accept is in IDLE, after DONE.
REQ-018 A zero magnitude SHALL produce result 0x00000000 (+0.0), with the same latency.
REQ-019 Denormals, Inf and NaN SHALL never be produced; the exponent range is 96..127.
REQ-020 If clk_en is low mid-operation, the FSM SHALL freeze and resume, with latency counted in enabled cycles; done SHALL stay high while frozen in DONE.

Reset
REQ-021 aclr high at an edge SHALL force IDLE, done=0, result=0x00000000, and clear the internal registers; this applies regardless of clk_en.
REQ-022 aclr mid-operation SHALL abort the conversion, and no done SHALL follow for the aborted request.
REQ-023 start asserted in the same cycle as aclr SHALL be ignored.

Configuration
REQ-024 With FIXED_TO_FLOAT_ROUND_EN defined, PACK SHALL round to nearest, ties to even, using guard, sticky and the fraction LSB.
REQ-025 With FIXED_TO_FLOAT_ROUND_EN defined, a fraction carry-out SHALL clear the fraction and increment the exponent.
REQ-026 Without FIXED_TO_FLOAT_ROUND_EN, PACK SHALL truncate (guard and sticky ignored), with identical latency and ports.

Structure
REQ-027 Package fixed_to_float_pkg SHALL hold the FSM state typedef, EXP_OFFSET=96, FRAC_W=23, NORM_STEPS=5 and LATENCY=7.
REQ-028 One combinational sub-module, fp_round_pack (sign, exponent, 32-bit normalised magnitude -> 32-bit word), SHALL contain rounding and the macro switch.

Verification
REQ-029 The bench SHALL run these directed scenarios:
- dataa 0x40000000 -> result 0x3F000000; done at enabled edge 7 only.
- dataa 0xC0000000 -> 0xBF000000; dataa 0x80000000 -> 0xBF800000; dataa 0x00000001 -> 0x30000000.
- dataa 0x6EC1BCCD -> 0x3F5D837A with rounding, 0x3F5D8379 without.
- dataa 0x7FFFFFFF -> 0x3F800000 with rounding (carry into exponent), 0x3F7FFFFF without.
- dataa 0x00000000 -> 0x00000000; a second start pulsed during NORM is ignored, giving exactly one done.
- clk_en low for 3 cycles in NORM -> done at enabled edge 7 (wall-clock edge 10); aclr at edge 3 -> no done, result 0x00000000.
